// File: rtl/tagged_gshare_predictor.sv
// -----------------------------------------------------------------------------
// tagged_gshare_predictor
//
// Tagged branch-direction predictor for the fetch stage. Each table entry holds
// a valid bit, a partial tag and a saturating counter. The table index is
// either the PC word index (bimodal, MODE=0) or that index XORed with the
// global history (gshare, MODE=1). The global history register (GHR) is
// updated speculatively with every prediction. A mispredicted branch repairs it
// from the snapshot returned with the update.
//
// Parameters
//   PC_WIDTH  : PC bits on the lookup and update ports
//   INDEX_LEN : table index width (2^INDEX_LEN entries)
//   TAG_LEN   : stored tag width (INDEX_LEN+TAG_LEN+2 <= PC_WIDTH)
//   CTR_BITS  : saturating counter width (>= 2)
//   GHR_LEN   : global history length (2 <= GHR_LEN <= INDEX_LEN)
//   MODE      : 1 = gshare indexing, 0 = bimodal indexing
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   predict_valid  in   lookup request this cycle
//   pc_read        in   lookup PC
//   pred_valid_out out  lookup result valid (one cycle after the request)
//   prediction     out  predicted direction, 1 = taken
//   pred_hit       out  lookup matched a valid entry with the same tag
//   pred_ghr       out  GHR value used for the lookup (returned with update)
//   update_valid   in   resolved-branch update this cycle
//   pc_write       in   resolved branch PC
//   update_ghr     in   pred_ghr captured when this branch was looked up
//   outcome        in   resolved direction, 1 = taken
//   mispredict     in   branch was mispredicted (qualified by update_valid)
// -----------------------------------------------------------------------------
module tagged_gshare_predictor #(
    parameter int PC_WIDTH  = 16,
    parameter int INDEX_LEN = 7,
    parameter int TAG_LEN   = 7,
    parameter int CTR_BITS  = 2,
    parameter int GHR_LEN   = 7,
    parameter int MODE      = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                predict_valid,
    input  logic [PC_WIDTH-1:0] pc_read,
    output logic                pred_valid_out,
    output logic                prediction,
    output logic                pred_hit,
    output logic [GHR_LEN-1:0]  pred_ghr,
    input  logic                update_valid,
    input  logic [PC_WIDTH-1:0] pc_write,
    input  logic [GHR_LEN-1:0]  update_ghr,
    input  logic                outcome,
    input  logic                mispredict
);

    localparam int ENTRIES = 1 << INDEX_LEN;

    // Counter encodings: weakly not-taken, weakly taken, saturation limits.
    localparam logic [CTR_BITS-1:0] CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_WT  = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0] CTR_ONE = {{(CTR_BITS-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Table storage. Every entry must clear on reset, so the table lives in
    // flops rather than block RAM.
    // -------------------------------------------------------------------------
    logic                entry_valid_q [ENTRIES];
    logic [TAG_LEN-1:0]  entry_tag_q   [ENTRIES];
    logic [CTR_BITS-1:0] entry_ctr_q   [ENTRIES];

    logic [GHR_LEN-1:0]  ghr_q;
    logic [GHR_LEN-1:0]  ghr_d;

    logic                pred_valid_q;
    logic                pred_valid_d;
    logic                prediction_q;
    logic                prediction_d;
    logic                pred_hit_q;
    logic                pred_hit_d;
    logic [GHR_LEN-1:0]  pred_ghr_q;
    logic [GHR_LEN-1:0]  pred_ghr_d;

    // -------------------------------------------------------------------------
    // Field extraction
    // -------------------------------------------------------------------------
    logic [INDEX_LEN-1:0] rd_hist_ext;
    logic [INDEX_LEN-1:0] wr_hist_ext;
    logic [INDEX_LEN-1:0] rd_idx;
    logic [INDEX_LEN-1:0] wr_idx;
    logic [TAG_LEN-1:0]   rd_tag;
    logic [TAG_LEN-1:0]   wr_tag;

    // History is zero-extended up to the index width before the XOR; in
    // bimodal mode it is forced to zero so only the PC selects the entry.
    always_comb begin
        rd_hist_ext = '0;
        wr_hist_ext = '0;
        if (MODE != 0) begin
            rd_hist_ext[GHR_LEN-1:0] = ghr_q;
            wr_hist_ext[GHR_LEN-1:0] = update_ghr;
        end
    end

    assign rd_idx = pc_read[INDEX_LEN+1:2]  ^ rd_hist_ext;
    assign wr_idx = pc_write[INDEX_LEN+1:2] ^ wr_hist_ext;
    assign rd_tag = pc_read[INDEX_LEN+TAG_LEN+1:INDEX_LEN+2];
    assign wr_tag = pc_write[INDEX_LEN+TAG_LEN+1:INDEX_LEN+2];

    // Low word-offset bits and any PC bits above the tag never influence the
    // table; fold them into a sink so the intent is explicit.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_read, pc_write, update_ghr};

    // -------------------------------------------------------------------------
    // Lookup path: combinational read of the current table contents. A write
    // landing in the same cycle is not bypassed, so the lookup always sees the
    // pre-update entry.
    // -------------------------------------------------------------------------
    logic rd_hit;
    logic rd_pred;

    assign rd_hit  = entry_valid_q[rd_idx] && (entry_tag_q[rd_idx] == rd_tag);
    assign rd_pred = rd_hit && entry_ctr_q[rd_idx][CTR_BITS-1];

    // -------------------------------------------------------------------------
    // Update path: read-modify-write of the indexed entry.
    // -------------------------------------------------------------------------
    logic                wr_hit;
    logic [CTR_BITS-1:0] wr_ctr_cur;
    logic [CTR_BITS-1:0] wr_ctr_new;

    assign wr_hit     = entry_valid_q[wr_idx] && (entry_tag_q[wr_idx] == wr_tag);
    assign wr_ctr_cur = entry_ctr_q[wr_idx];

    always_comb begin
        wr_ctr_new = wr_ctr_cur;
        if (!wr_hit) begin
            // Allocation (or overwrite on tag conflict) starts weakly biased.
            wr_ctr_new = outcome ? CTR_WT : CTR_WNT;
        end else if (outcome) begin
            if (wr_ctr_cur != CTR_MAX) begin
                wr_ctr_new = wr_ctr_cur + CTR_ONE;
            end
        end else begin
            if (wr_ctr_cur != CTR_MIN) begin
                wr_ctr_new = wr_ctr_cur - CTR_ONE;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic entry_we;
            assign entry_we = update_valid && (wr_idx == INDEX_LEN'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    entry_valid_q[gi] <= 1'b0;
                    entry_tag_q[gi]   <= '0;
                    entry_ctr_q[gi]   <= CTR_WNT;
                end else if (entry_we) begin
                    entry_valid_q[gi] <= 1'b1;
                    entry_tag_q[gi]   <= wr_tag;
                    entry_ctr_q[gi]   <= wr_ctr_new;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Global history. A mispredict repair rebuilds the history from the
    // snapshot the branch was predicted with plus its real outcome; any
    // speculative shift from a lookup in the same cycle belongs to the wrong
    // path and is discarded.
    // -------------------------------------------------------------------------
    always_comb begin
        ghr_d = ghr_q;
        if (update_valid && mispredict) begin
            ghr_d = {update_ghr[GHR_LEN-2:0], outcome};
        end else if (predict_valid) begin
            ghr_d = {ghr_q[GHR_LEN-2:0], rd_pred};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Registered lookup result. The valid strobe is a pure one-cycle echo of
    // the request; the payload holds between lookups.
    // -------------------------------------------------------------------------
    always_comb begin
        pred_valid_d = predict_valid;
        prediction_d = prediction_q;
        pred_hit_d   = pred_hit_q;
        pred_ghr_d   = pred_ghr_q;
        if (predict_valid) begin
            prediction_d = rd_pred;
            pred_hit_d   = rd_hit;
            pred_ghr_d   = ghr_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_valid_q <= 1'b0;
            prediction_q <= 1'b0;
            pred_hit_q   <= 1'b0;
            pred_ghr_q   <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            prediction_q <= prediction_d;
            pred_hit_q   <= pred_hit_d;
            pred_ghr_q   <= pred_ghr_d;
        end
    end

    assign pred_valid_out = pred_valid_q;
    assign prediction     = prediction_q;
    assign pred_hit       = pred_hit_q;
    assign pred_ghr       = pred_ghr_q;

endmodule

// File: tb/tb_tagged_gshare_predictor.sv
// -----------------------------------------------------------------------------
// tb_tagged_gshare_predictor
//
// Two predictor instances: index 0 is bimodal (MODE=0), index 1 is gshare
// (MODE=1). Each has its own stimulus signals. One stimulus record is applied
// per cycle; expected lookup results are queued when the lookup is driven and
// popped when the DUT raises pred_valid_out.
// -----------------------------------------------------------------------------
module tb_tagged_gshare_predictor;

    typedef struct packed {
        logic        pv;
        logic [15:0] pcr;
        logic        uv;
        logic [15:0] pcw;
        logic [6:0]  ughr;
        logic        outc;
        logic        mis;
        logic        e_pred;
        logic        e_hit;
        logic [6:0]  e_ghr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pv      [2];
    logic [15:0] pcr     [2];
    logic        uv      [2];
    logic [15:0] pcw     [2];
    logic [6:0]  ughr    [2];
    logic        outc    [2];
    logic        mis     [2];
    logic        pvo     [2];
    logic        pred    [2];
    logic        hit     [2];
    logic [6:0]  pghr    [2];

    int n_checks = 0;
    int n_errors = 0;

    vec_t sb [$];
    logic        last_pred [2];
    logic        last_hit  [2];
    logic [6:0]  last_ghr  [2];

    always #5 clk = ~clk;

    tagged_gshare_predictor #(
        .PC_WIDTH(16), .INDEX_LEN(7), .TAG_LEN(7), .CTR_BITS(2), .GHR_LEN(7), .MODE(0)
    ) u_dut_bim (
        .clk(clk), .reset(reset_n),
        .predict_valid(pv[0]), .pc_read(pcr[0]),
        .pred_valid_out(pvo[0]), .prediction(pred[0]), .pred_hit(hit[0]), .pred_ghr(pghr[0]),
        .update_valid(uv[0]), .pc_write(pcw[0]), .update_ghr(ughr[0]),
        .outcome(outc[0]), .mispredict(mis[0])
    );

    tagged_gshare_predictor #(
        .PC_WIDTH(16), .INDEX_LEN(7), .TAG_LEN(7), .CTR_BITS(2), .GHR_LEN(7), .MODE(1)
    ) u_dut_gsh (
        .clk(clk), .reset(reset_n),
        .predict_valid(pv[1]), .pc_read(pcr[1]),
        .pred_valid_out(pvo[1]), .prediction(pred[1]), .pred_hit(hit[1]), .pred_ghr(pghr[1]),
        .update_valid(uv[1]), .pc_write(pcw[1]), .update_ghr(ughr[1]),
        .outcome(outc[1]), .mispredict(mis[1])
    );

    function automatic vec_t mk(input logic p, input logic [15:0] a, input logic u,
                                input logic [15:0] b, input logic [6:0] g, input logic o,
                                input logic m, input logic ep, input logic eh,
                                input logic [6:0] eg);
        vec_t v;
        v.pv = p; v.pcr = a; v.uv = u; v.pcw = b; v.ughr = g; v.outc = o; v.mis = m;
        v.e_pred = ep; v.e_hit = eh; v.e_ghr = eg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            pv[k] = 1'b0; pcr[k] = '0; uv[k] = 1'b0; pcw[k] = '0;
            ughr[k] = '0; outc[k] = 1'b0; mis[k] = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus on DUT m, then check its registered result.
    task automatic step(input int m, input vec_t v, input string tag);
        vec_t e;
        idle_all();
        pv[m] = v.pv; pcr[m] = v.pcr; uv[m] = v.uv; pcw[m] = v.pcw;
        ughr[m] = v.ughr; outc[m] = v.outc; mis[m] = v.mis;
        if (v.pv) sb.push_back(v);
        @(posedge clk);
        #1;
        $display("%s dut%0d pv=%0b pc_rd=%h uv=%0b pc_wr=%h ughr=%b out=%0b mis=%0b -> valid=%0b pred=%0b hit=%0b ghr=%b",
                 tag, m, v.pv, v.pcr, v.uv, v.pcw, v.ughr, v.outc, v.mis,
                 pvo[m], pred[m], hit[m], pghr[m]);
        chk({tag, " valid"}, 32'(pvo[m]), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " prediction"}, 32'(pred[m]), 32'(e.e_pred));
            chk({tag, " hit"},        32'(hit[m]),  32'(e.e_hit));
            chk({tag, " ghr"},        32'(pghr[m]), 32'(e.e_ghr));
            last_pred[m] = e.e_pred;
            last_hit[m]  = e.e_hit;
            last_ghr[m]  = e.e_ghr;
        end else begin
            chk({tag, " hold prediction"}, 32'(pred[m]), 32'(last_pred[m]));
            chk({tag, " hold hit"},        32'(hit[m]),  32'(last_hit[m]));
            chk({tag, " hold ghr"},        32'(pghr[m]), 32'(last_ghr[m]));
        end
    endtask

    task automatic clear_last();
        sb.delete();
        for (int k = 0; k < 2; k++) begin
            last_pred[k] = 1'b0; last_hit[k] = 1'b0; last_ghr[k] = '0;
        end
    endtask

    localparam int NV = 21;
    vec_t vecs [NV];

    initial begin
        // Bimodal (MODE=0) table: training, saturation, tag conflict, no bypass.
        //               pv  pc_rd      uv  pc_wr     ughr  out  mis  pred hit ghr
        vecs[0]  = mk(1, 16'h0104, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h00); // cold miss
        vecs[1]  = mk(0, 16'h0000, 1, 16'h0104, 7'h00, 1, 0, 0, 0, 7'h00); // alloc ctr=2
        vecs[2]  = mk(1, 16'h0104, 0, 16'h0000, 7'h00, 0, 0, 1, 1, 7'h00);
        vecs[3]  = mk(0, 16'h0000, 1, 16'h0104, 7'h00, 0, 0, 0, 0, 7'h00); // ctr 1
        vecs[4]  = mk(0, 16'h0000, 1, 16'h0104, 7'h00, 0, 0, 0, 0, 7'h00); // ctr 0
        vecs[5]  = mk(0, 16'h0000, 1, 16'h0104, 7'h00, 0, 0, 0, 0, 7'h00); // ctr 0 (sat)
        vecs[6]  = mk(1, 16'h0104, 0, 16'h0000, 7'h00, 0, 0, 0, 1, 7'h01);
        vecs[7]  = mk(0, 16'h0000, 1, 16'h0104, 7'h00, 1, 0, 0, 0, 7'h00); // ctr 1
        vecs[8]  = mk(0, 16'h0000, 1, 16'h0104, 7'h00, 1, 0, 0, 0, 7'h00); // ctr 2
        vecs[9]  = mk(0, 16'h0000, 1, 16'h0104, 7'h00, 1, 0, 0, 0, 7'h00); // ctr 3
        vecs[10] = mk(0, 16'h0000, 1, 16'h0104, 7'h00, 1, 0, 0, 0, 7'h00); // ctr 3 (sat)
        vecs[11] = mk(0, 16'h0000, 1, 16'h0104, 7'h00, 0, 0, 0, 0, 7'h00); // ctr 2
        vecs[12] = mk(1, 16'h0104, 0, 16'h0000, 7'h00, 0, 0, 1, 1, 7'h02);
        vecs[13] = mk(0, 16'h0000, 1, 16'h0104, 7'h00, 1, 0, 0, 0, 7'h00); // ctr 3
        vecs[14] = mk(0, 16'h0000, 1, 16'h0304, 7'h00, 0, 0, 0, 0, 7'h00); // tag 1 ctr=1
        vecs[15] = mk(1, 16'h0104, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h05); // evicted
        vecs[16] = mk(1, 16'h0304, 0, 16'h0000, 7'h00, 0, 0, 0, 1, 7'h0A);
        vecs[17] = mk(1, 16'h0304, 1, 16'h0304, 7'h00, 1, 0, 0, 1, 7'h14); // no bypass
        vecs[18] = mk(1, 16'h0304, 0, 16'h0000, 7'h00, 0, 0, 1, 1, 7'h28);
        vecs[19] = mk(1, 16'h0304, 1, 16'h0108, 7'h00, 1, 0, 1, 1, 7'h51); // other index
        vecs[20] = mk(1, 16'h0108, 0, 16'h0000, 7'h00, 0, 0, 1, 1, 7'h23);

        idle_all();
        clear_last();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("reset valid",      32'(pvo[0]),  32'd0);
        chk("reset prediction", 32'(pred[0]), 32'd0);
        chk("reset hit",        32'(hit[0]),  32'd0);
        chk("reset ghr",        32'(pghr[0]), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        step(0, mk(0, 16'h0, 0, 16'h0, 7'h00, 0, 0, 0, 0, 7'h00), "post-reset idle");
        for (int i = 0; i < NV; i++) begin
            step(0, vecs[i], $sformatf("bim[%0d]", i));
        end

        // Gshare (MODE=1): misses keep GHR at zero, then a mispredict repair
        // collides with a lookup and must win.
        step(1, mk(1, 16'h0104, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h00), "gsh miss0");
        step(1, mk(1, 16'h0204, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h00), "gsh miss1");
        step(1, mk(1, 16'h0404, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h00), "gsh miss2");
        step(1, mk(1, 16'h0104, 1, 16'h0800, 7'h05, 1, 1, 0, 0, 7'h00), "gsh repair");
        step(1, mk(1, 16'h0104, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h0B), "gsh after repair");
        // pc 0x084C with GHR 0x16 indexes entry 5 tag 4, allocated by the repair update.
        step(1, mk(1, 16'h084C, 0, 16'h0000, 7'h00, 0, 0, 1, 1, 7'h16), "gsh hashed hit");
        step(1, mk(0, 16'h0000, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h00), "gsh idle");

        // Asynchronous reset in the middle of a valid result.
        step(0, mk(1, 16'h0304, 0, 16'h0000, 7'h00, 0, 0, 1, 1, 7'h47), "pre-reset lookup");
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset valid",      32'(pvo[0]),  32'd0);
        chk("async reset prediction", 32'(pred[0]), 32'd0);
        chk("async reset hit",        32'(hit[0]),  32'd0);
        chk("async reset ghr",        32'(pghr[0]), 32'd0);
        chk("async reset gsh ghr",    32'(pghr[1]), 32'd0);
        pv[0] = 1'b1; pcr[0] = 16'h0304; uv[0] = 1'b1; pcw[0] = 16'h0104; outc[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("in-reset valid", 32'(pvo[0]),  32'd0);
        chk("in-reset pred",  32'(pred[0]), 32'd0);
        idle_all();
        clear_last();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, mk(1, 16'h0304, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h00), "post-reset 0304");
        step(0, mk(1, 16'h0104, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h00), "post-reset 0104");
        step(0, mk(1, 16'h0108, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h00), "post-reset 0108");
        step(1, mk(1, 16'h084C, 0, 16'h0000, 7'h00, 0, 0, 0, 0, 7'h00), "post-reset gsh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tagged_gshare_predictor.md
# tagged_gshare_predictor

Parametrised, tagged branch direction predictor for the fetch stage of the simple CPU. Supersedes the fixed-width bimodal predictor and adds configurable counter width, a speculative global history register (GHR) with mispredict recovery, gshare/bimodal mode select, and a registered one-cycle lookup. Fetch issues lookups. The branch resolution unit returns updates together with the GHR snapshot captured at lookup.

## Interface
Parameters:
- PC_WIDTH, 16, PC bits presented on the lookup and update ports.
- INDEX_LEN, 7, table index width. The table has 2^INDEX_LEN entries.
- TAG_LEN, 7, stored tag width. Requires INDEX_LEN+TAG_LEN+2 <= PC_WIDTH.
- CTR_BITS, 2, saturating counter width. Must be >= 2.
- GHR_LEN, 7, global history length. Must be <= INDEX_LEN.
- MODE, 1, 1 selects gshare indexing, 0 selects bimodal indexing (no GHR in the index).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- predict_valid  in  1  lookup request this cycle.
- pc_read  in  PC_WIDTH  lookup PC.
- pred_valid_out  out  1  lookup result valid.
- prediction  out  1  1 = taken.
- pred_hit  out  1  tag matched a valid entry.
- pred_ghr  out  GHR_LEN  GHR value used for this lookup. Carried down the pipeline and returned with the update.
- update_valid  in  1  resolved-branch update this cycle.
- pc_write  in  PC_WIDTH  resolved branch PC.
- update_ghr  in  GHR_LEN  pred_ghr returned with this branch.
- outcome  in  1  actual direction, 1 = taken.
- mispredict  in  1  branch was mispredicted. Qualified by update_valid.

## Operation
Field extraction:
- idx = pc[INDEX_LEN+1:2] XOR (MODE ? zero-extended history : 0).
- Reads use the live GHR as history. Writes use update_ghr.
- tag = pc[INDEX_LEN+TAG_LEN+1:INDEX_LEN+2].

Entry contents: valid, tag[TAG_LEN], ctr[CTR_BITS].
- WNT = 2^(CTR_BITS-1)-1 (weakly not-taken).
- WT = 2^(CTR_BITS-1) (weakly taken).

Lookup:
- hit = valid && stored tag == read tag.
- Predicted direction = hit ? ctr[MSB] : 0.

Update, when update_valid = 1:
- On hit, ctr saturates toward outcome: increment clamps at 2^CTR_BITS-1, decrement clamps at 0.
- On miss (invalid or tag mismatch), the entry is allocated or overwritten: valid = 1, tag = write tag, ctr = outcome ? WT : WNT.
- There is no replacement policy; a miss always overwrites.

GHR, shifted left with the newest bit in bit 0:
- If update_valid && mispredict: GHR <= {update_ghr[GHR_LEN-2:0], outcome}. This repair has priority over a same-cycle speculative shift, which is then dropped.
- Else if predict_valid: GHR <= {GHR[GHR_LEN-2:0], predicted direction}.
- Otherwise GHR holds.
- The GHR is maintained in both modes. MODE only affects indexing.

Reset (asynchronous, active-low):
- Every entry: valid = 0, ctr = WNT.
- GHR = 0.
- pred_valid_out, prediction, pred_hit, pred_ghr = 0.
- Reset asserted mid-operation discards any in-flight lookup and update. No output glitches to a nonzero value while reset is low.

## Timing
- Lookup latency is 1 cycle. predict_valid at cycle N gives pred_valid_out, prediction, pred_hit, pred_ghr registered at the edge ending N and visible in N+1.
- pred_valid_out is 0 in any cycle following a cycle without predict_valid. The other result outputs hold their last value.
- Back-to-back lookups are sustained one per cycle. Consecutive lookups see each other's speculative GHR shift.
- An update is written at the edge ending its cycle and is visible to lookups from the next cycle.
- A same-cycle lookup and update to the same index has no bypass: the lookup sees the pre-update entry.
- Simultaneous lookup and update to different indices are both performed.
- Updates have no handshake and are accepted every cycle.

## Test plan
- After reset release, lookup pc_read=0x0104 -> next cycle pred_valid_out=1, prediction=0, pred_hit=0, pred_ghr=0. GHR afterward = 0x00.
- MODE=0: update pc_write=0x0104, outcome=1, mispredict=0 -> ctr=2. Lookup 0x0104 -> prediction=1, pred_hit=1. Then three not-taken updates -> ctr 1, 0, 0 (saturated), and lookup gives prediction=0, pred_hit=1.
- MODE=0: four taken updates to 0x0104 -> ctr=3. One not-taken -> ctr=2, and lookup still gives prediction=1.
- MODE=0, tag conflict (index 0x41 for both, tags 0 vs 1): taken update 0x0104, then not-taken update 0x0304 -> lookup 0x0104 gives pred_hit=0, prediction=0. Lookup 0x0304 gives pred_hit=1, prediction=0.
- MODE=1, GHR recovery: three lookups with misses -> pred_ghr returns 0, 0, 0. Then the same cycle carries predict_valid=1 and update_valid=1, mispredict=1, update_ghr=7'b0000101, outcome=1 -> GHR=7'b0001011 and the speculative shift is dropped. The next lookup returns pred_ghr=7'b0001011.
- Drive reset low mid-stream with pred_valid_out=1 -> all outputs 0 immediately without a clock edge. After release, lookups of previously trained PCs return pred_hit=0.
